pwm_ramp_sequencer: RTL and testbench

- Controller for the 10-bit free-running PWM counter and its duty comparator.
- Owns the counter enable and the duty value fed to the comparator.
- Accepts target-duty requests over a valid/ready handshake and ramps duty toward the target by a programmable step.
- Duty updates land only at period boundaries, so no PWM period ever sees a torn duty value (soft-start / glitch-free retarget).

---
 rtl/pwm_ramp_sequencer_pkg.sv | 20 ++
 rtl/pwm_period_tick.sv | 55 +++++
 rtl/pwm_ramp_sequencer.sv | 174 +++++++++++++++++
 tb/tb_pwm_ramp_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ramp_sequencer_pkg.sv
// ---------------------------------------------------------------------------------------------
// pwm_ramp_sequencer_pkg
//   Shared definitions for the PWM ramp sequencer, the PWM counter and the duty comparator:
//   default counter/duty width and terminal count, ramp input widths and the sequencer state
//   encoding.
// ---------------------------------------------------------------------------------------------
package pwm_ramp_sequencer_pkg;

    localparam int unsigned CNT_W_DEF   = 10;
    localparam int unsigned CNT_MAX_DEF = (1 << CNT_W_DEF) - 1;
    localparam int unsigned STEP_W_DEF  = 4;
    localparam int unsigned DWELL_W_DEF = 8;

    typedef enum logic [1:0] {
        StOff  = 2'd0,
        StHold = 2'd1,
        StRamp = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_period_tick.sv
// ---------------------------------------------------------------------------------------------
// pwm_period_tick
//   Detects PWM period boundaries (enabled counter at terminal count) and counts dwell periods
//   between duty steps. Emits a one-cycle step tick on the boundary where the dwell count has
//   run out.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   cntr_i       PWM counter value
//   cntr_en_i    counter enable as driven by the sequencer
//   active_i     ramp in progress; dwell counting only happens while set
//   load_i       restart dwell counting (request accepted this cycle)
//   dwell_i      periods per step, already forced non-zero by the caller
//   step_tick_o  one-cycle pulse: take a duty step on this boundary edge
// ---------------------------------------------------------------------------------------------
module pwm_period_tick
    import pwm_ramp_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned CNT_MAX = CNT_MAX_DEF,
    parameter int unsigned DWELL_W = DWELL_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CNT_W-1:0]   cntr_i,
    input  logic               cntr_en_i,
    input  logic               active_i,
    input  logic               load_i,
    input  logic [DWELL_W-1:0] dwell_i,
    output logic               step_tick_o
);

    logic               w_boundary;
    logic               w_dwell_zero;
    logic [DWELL_W-1:0] r_dwell_cnt;

    // A stopped counter parks at CNT_MAX; the enable qualifier keeps that from looking like a wrap.
    assign w_boundary   = cntr_en_i && (cntr_i == CNT_W'(CNT_MAX));
    assign w_dwell_zero = (r_dwell_cnt == '0);

    // Load beats a coincident boundary so dwell counting starts only after acceptance.
    assign step_tick_o = active_i && !load_i && w_boundary && w_dwell_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dwell_cnt <= '0;
        end else if (load_i) begin
            r_dwell_cnt <= dwell_i - DWELL_W'(1);
        end else if (active_i && w_boundary) begin
            r_dwell_cnt <= w_dwell_zero ? dwell_i - DWELL_W'(1) : r_dwell_cnt - DWELL_W'(1);
        end
    end

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// ---------------------------------------------------------------------------------------------
// pwm_ramp_sequencer
//   Controls the free-running PWM counter enable and the duty value fed to the comparator.
//   Target-duty requests arrive over valid/ready; duty ramps toward the target by a step every
//   'dwell' PWM periods. Duty only changes on the period-boundary edge, so every period sees
//   one consistent duty value.
//
// Optional build macro
//   PWM_RAMP_DONE_IRQ_EN  adds done_o, a one-cycle pulse on the cycle after a ramp completes.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   en_i         global PWM enable
//   cntr_i       PWM counter value
//   tgt_duty_i   requested target duty
//   tgt_step_i   duty increment per step (0 behaves as 1)
//   tgt_dwell_i  PWM periods per step (0 behaves as 1)
//   tgt_valid_i  request valid
//   tgt_ready_o  request ready (accepted when valid && ready on a clk edge)
//   cntr_en_o    PWM counter enable
//   duty_o       duty to the comparator
//   busy_o       ramp in progress
//   done_o       ramp-complete pulse (PWM_RAMP_DONE_IRQ_EN builds only)
// ---------------------------------------------------------------------------------------------
module pwm_ramp_sequencer
    import pwm_ramp_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned CNT_MAX = CNT_MAX_DEF,
    parameter int unsigned STEP_W  = STEP_W_DEF,
    parameter int unsigned DWELL_W = DWELL_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic [CNT_W-1:0]   cntr_i,
    input  logic [CNT_W-1:0]   tgt_duty_i,
    input  logic [STEP_W-1:0]  tgt_step_i,
    input  logic [DWELL_W-1:0] tgt_dwell_i,
    input  logic               tgt_valid_i,
    output logic               tgt_ready_o,
    output logic               cntr_en_o,
    output logic [CNT_W-1:0]   duty_o,
    output logic               busy_o
`ifdef PWM_RAMP_DONE_IRQ_EN
    ,
    output logic               done_o
`endif
);

    state_t               r_state;
    state_t               w_state_next;

    logic [CNT_W-1:0]     r_duty;
    logic [CNT_W-1:0]     r_target;
    logic [STEP_W-1:0]    r_step;
    logic [DWELL_W-1:0]   r_dwell;

    logic                 w_handshake;
    logic [STEP_W-1:0]    w_step_eff;
    logic [DWELL_W-1:0]   w_dwell_eff;
    logic [DWELL_W-1:0]   w_dwell_sel;
    logic                 w_ramp_active;
    logic                 w_step_tick;
    logic signed [CNT_W:0] w_diff;
    logic [CNT_W:0]       w_abs_diff;
    logic                 w_last_step;
    logic                 w_ramp_done;

    assign w_handshake   = tgt_valid_i && tgt_ready_o;
    assign w_step_eff    = (tgt_step_i == '0) ? STEP_W'(1) : tgt_step_i;
    assign w_dwell_eff   = (tgt_dwell_i == '0) ? DWELL_W'(1) : tgt_dwell_i;
    assign w_dwell_sel   = w_handshake ? w_dwell_eff : r_dwell;
    assign w_ramp_active = (r_state == StRamp);

    // One extra bit keeps the signed distance exact across the whole duty range.
    assign w_diff      = $signed({1'b0, r_target}) - $signed({1'b0, r_duty});
    assign w_abs_diff  = w_diff[CNT_W] ? $unsigned(-w_diff) : $unsigned(w_diff);
    assign w_last_step = (w_abs_diff <= (CNT_W+1)'(r_step));
    assign w_ramp_done = w_ramp_active && w_step_tick && w_last_step;

    pwm_period_tick #(
        .CNT_W   (CNT_W),
        .CNT_MAX (CNT_MAX),
        .DWELL_W (DWELL_W)
    ) u_period_tick (
        .clk         (clk),
        .rst         (rst),
        .cntr_i      (cntr_i),
        .cntr_en_i   (cntr_en_o),
        .active_i    (w_ramp_active),
        .load_i      (w_handshake),
        .dwell_i     (w_dwell_sel),
        .step_tick_o (w_step_tick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StOff;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StOff: begin
                if (en_i) w_state_next = StHold;
            end
            StHold: begin
                if (!en_i)            w_state_next = StOff;
                else if (w_handshake) w_state_next = StRamp;
            end
            StRamp: begin
                if (!en_i)            w_state_next = StOff;
                else if (w_ramp_done) w_state_next = StHold;
            end
            default: w_state_next = StOff;
        endcase
    end

    // Request latch and duty update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_target <= '0;
            r_step   <= '0;
            r_dwell  <= '0;
            r_duty   <= '0;
        end else begin
            if (w_handshake) begin
                r_target <= tgt_duty_i;
                r_step   <= w_step_eff;
                r_dwell  <= w_dwell_eff;
            end
            if (!en_i) begin
                r_duty <= '0;
            end else if (w_ramp_active && w_step_tick) begin
                // Final step snaps to target, so no overshoot and no wrap at either end.
                if (w_last_step)         r_duty <= r_target;
                else if (w_diff[CNT_W])  r_duty <= r_duty - CNT_W'(r_step);
                else                     r_duty <= r_duty + CNT_W'(r_step);
            end
        end
    end

`ifdef PWM_RAMP_DONE_IRQ_EN
    logic r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_ramp_done && en_i;
        end
    end
`endif

    // Outputs.
    always_comb begin
        cntr_en_o   = (r_state != StOff);
        tgt_ready_o = (r_state == StHold) && en_i;
        busy_o      = (r_state == StRamp);
        duty_o      = r_duty;
`ifdef PWM_RAMP_DONE_IRQ_EN
        // Pulse is dropped if enable falls or reset arrives during the pulse cycle.
        done_o      = r_done && en_i && !rst;
`endif
    end

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// ---------------------------------------------------------------------------------------------
// tb_pwm_ramp_sequencer
//   Self-checking bench for pwm_ramp_sequencer. A behavioural PWM counter drives cntr_i; its
//   period can be shortened (wrap from per_last straight to CNT_MAX) to keep long ramps cheap.
//   Build with +define+PWM_RAMP_DONE_IRQ_EN to also check done_o.
// ---------------------------------------------------------------------------------------------
module tb_pwm_ramp_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_i;
    logic [9:0] cntr;
    logic [9:0] tgt_duty;
    logic [3:0] tgt_step;
    logic [7:0] tgt_dwell;
    logic       tgt_valid;
    logic       ready;
    logic       cntr_en;
    logic [9:0] duty;
    logic       busy;
`ifdef PWM_RAMP_DONE_IRQ_EN
    logic       done;
`endif

    int n_vec = 0;
    int n_err = 0;
    int per_last = 1022;

    always #5 clk = ~clk;

    pwm_ramp_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en_i),
        .cntr_i      (cntr),
        .tgt_duty_i  (tgt_duty),
        .tgt_step_i  (tgt_step),
        .tgt_dwell_i (tgt_dwell),
        .tgt_valid_i (tgt_valid),
        .tgt_ready_o (ready),
        .cntr_en_o   (cntr_en),
        .duty_o      (duty),
        .busy_o      (busy)
`ifdef PWM_RAMP_DONE_IRQ_EN
        ,
        .done_o      (done)
`endif
    );

    // Behavioural PWM counter: parks at 1023 while disabled.
    always_ff @(posedge clk) begin
        if (rst || !cntr_en)               cntr <= 10'd1023;
        else if (cntr == 10'd1023)         cntr <= 10'd0;
        else if (cntr >= 10'(per_last))    cntr <= 10'd1023;
        else                               cntr <= cntr + 10'd1;
    end

    typedef struct {
        int per_last;
        int tgt;
        int step;
        int dwell;
        int n_steps;
        int first;
        int fin;
        int gap;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_req(input int tgt, input int step, input int dwell);
        bit ok;
        ok = 1'b0;
        tgt_duty  = 10'(tgt);
        tgt_step  = 4'(step);
        tgt_dwell = 8'(dwell);
        tgt_valid = 1'b1;
        for (int c = 0; c < 200 && !ok; c++) begin
            #1;
            if (ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        tgt_valid = 1'b0;
        if (!ok) check("req_timeout", ready, 1);
    endtask

    task automatic wait_duty(input int val);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 5000 && !ok; c++) begin
            if (duty == 10'(val)) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!ok) check("wait_duty_timeout", duty, val);
    endtask

    task automatic run_ramp(input int idx);
        int  prev;
        int  changes;
        int  t;
        int  t_last;
        bit  ended;
        check("busy_on", busy, 1);
        prev    = int'(duty);
        changes = 0;
        t       = 0;
        t_last  = 0;
        ended   = 1'b0;
        for (int c = 0; c < 20000 && !ended; c++) begin
            @(posedge clk);
            #1;
            t++;
            if (int'(duty) != prev) begin
                changes++;
                check("step_at_wrap", cntr, 0);
                if (changes == 1)           check("first_step", duty, vecs[idx].first);
                else if (vecs[idx].gap != 0) check("step_gap", t - t_last, vecs[idx].gap);
                t_last = t;
                prev   = int'(duty);
            end
            if (!busy) begin
                ended = 1'b1;
                check("busy_fall_at_wrap", cntr, 0);
                check("final_duty", duty, vecs[idx].fin);
                check("n_steps", changes, vecs[idx].n_steps);
                check("ready_back", ready, 1);
`ifdef PWM_RAMP_DONE_IRQ_EN
                check("done_pulse", done, 1);
                @(posedge clk);
                #1;
                check("done_single", done, 0);
`endif
            end
        end
        if (!ended) check("ramp_timeout", busy, 0);
    endtask

    initial begin
        int t;
        bit ok;

        //          per   tgt  step dw  n   first fin  gap
        vecs[0] = '{1022, 100,  10, 1, 10,   10,  100, 1024};
        vecs[1] = '{  30,  95,  15, 1,  1,   95,   95,   32};
        vecs[2] = '{  30,   7,  15, 1,  6,   80,    7,   32};
        vecs[3] = '{  30,   0,  15, 1,  1,    0,    0,   32};
        vecs[4] = '{  30, 1020, 15, 1, 68,   15, 1020,   32};
        vecs[5] = '{  30, 1023,  0, 3,  3, 1021, 1023,   96};
        vecs[6] = '{  30, 1023,  5, 2,  0,    0, 1023,    0};

        rst       = 1'b1;
        en_i      = 1'b0;
        tgt_duty  = '0;
        tgt_step  = '0;
        tgt_dwell = '0;
        tgt_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cntr_en", cntr_en, 0);
        check("rst_duty", duty, 0);
        check("rst_ready", ready, 0);
        check("rst_busy", busy, 0);
`ifdef PWM_RAMP_DONE_IRQ_EN
        check("rst_done", done, 0);
`endif

        // Enable: counter enable rises one edge later.
        rst  = 1'b0;
        en_i = 1'b1;
        #1;
        check("off_cntr_en", cntr_en, 0);
        check("off_ready", ready, 0);
        @(posedge clk);
        #1;
        check("hold_cntr_en", cntr_en, 1);
        check("hold_ready", ready, 1);
        check("hold_duty", duty, 0);
        check("hold_busy", busy, 0);

        // Table of ramps, each starting from the previous final duty.
        for (int i = 0; i < 7; i++) begin
            per_last = vecs[i].per_last;
            send_req(vecs[i].tgt, vecs[i].step, vecs[i].dwell);
            run_ramp(i);
        end

        // Request accepted on a boundary edge: first step waits a full period.
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            if (cntr == 10'd1023) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!ok) check("find_wrap_timeout", cntr, 1023);
        tgt_duty  = 10'd1013;
        tgt_step  = 4'd10;
        tgt_dwell = 8'd1;
        tgt_valid = 1'b1;
        #1;
        check("coinc_ready", ready, 1);
        @(posedge clk);
        #1;
        tgt_valid = 1'b0;
        check("coinc_busy", busy, 1);
        check("coinc_duty_held", duty, 1023);
        t  = 0;
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(posedge clk);
            #1;
            t++;
            if (duty != 10'd1023) ok = 1'b1;
        end
        check("coinc_delay", t, 32);
        check("coinc_duty", duty, 1013);
        check("coinc_done_busy", busy, 0);

        // Disable from HOLD, then re-enable.
        en_i = 1'b0;
        #1;
        check("dis_ready_comb", ready, 0);
        @(posedge clk);
        #1;
        check("dis_cntr_en", cntr_en, 0);
        check("dis_duty", duty, 0);
        en_i = 1'b1;
        @(posedge clk);
        #1;
        check("reen_cntr_en", cntr_en, 1);

        // Disable mid-ramp at duty 40 with a request pending.
        send_req(100, 10, 1);
        wait_duty(40);
        en_i      = 1'b0;
        tgt_duty  = 10'd500;
        tgt_valid = 1'b1;
        #1;
        check("drop_ready_comb", ready, 0);
        @(posedge clk);
        #1;
        check("drop_cntr_en", cntr_en, 0);
        check("drop_duty", duty, 0);
        check("drop_busy", busy, 0);
        check("drop_ready", ready, 0);
        @(posedge clk);
        #1;
        check("off_ready_held", ready, 0);
        check("off_cntr_en_held", cntr_en, 0);
        tgt_valid = 1'b0;
        en_i      = 1'b1;
        @(posedge clk);
        #1;
        check("reen2_cntr_en", cntr_en, 1);
        check("reen2_duty", duty, 0);
        check("reen2_busy", busy, 0);
        check("reen2_ready", ready, 1);

        // Reset mid-ramp.
        send_req(50, 10, 1);
        wait_duty(20);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_cntr_en", cntr_en, 0);
        check("mrst_duty", duty, 0);
        check("mrst_ready", ready, 0);
        check("mrst_busy", busy, 0);
        rst = 1'b0;
`ifdef PWM_RAMP_DONE_IRQ_EN
        check("mrst_done", done, 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("mrst_no_done", done, 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
